// File: rtl/sd_crc_pkg.sv
// rtl/sd_crc_pkg.sv - shared states and constants for the SD serial CRC engines
package sd_crc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } crc_state_t;

    localparam logic [6:0]  SD_CRC7_POLY  = 7'h09;
    localparam logic [15:0] SD_CRC16_POLY = 16'h1021;
    localparam int          SD_CMD_BITS   = 40;
    localparam int          SD_BLK_BITS   = 4096;

endpackage

// File: rtl/sd_crc_lfsr_step.sv
// rtl/sd_crc_lfsr_step.sv - combinational single-bit CRC LFSR update
module sd_crc_lfsr_step #(
    parameter int               CRC_W = 7,
    parameter logic [CRC_W-1:0] POLY  = 7'h09
) (
    input  logic [CRC_W-1:0] crc,
    input  logic             din,
    output logic [CRC_W-1:0] crc_next
);

    logic inv;

    assign inv      = din ^ crc[CRC_W-1];
    assign crc_next = {crc[CRC_W-2:0], 1'b0} ^ (inv ? POLY : {CRC_W{1'b0}});

endmodule

// File: rtl/sd_crc_serial.sv
// rtl/sd_crc_serial.sv - serial MSB-first CRC engine with start/busy/done handshake
// Optional received-CRC compare (crc_i/crc_err) is compiled in with SD_CRC_CHECK_EN.
module sd_crc_serial
    import sd_crc_pkg::*;
#(
    parameter int               CRC_W  = 7,
    parameter logic [CRC_W-1:0] POLY   = SD_CRC7_POLY,
    parameter int               DATA_W = SD_CMD_BITS,
    parameter logic [CRC_W-1:0] INIT   = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] data_i,
`ifdef SD_CRC_CHECK_EN
    input  logic [CRC_W-1:0]  crc_i,
`endif
    output logic              busy,
    output logic              done,
    output logic [CRC_W-1:0]  crc_o
`ifdef SD_CRC_CHECK_EN
    ,
    output logic              crc_err
`endif
);

    // A single-bit message still needs a one-bit counter to stay legal.
    localparam int              CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    crc_state_t        state, state_n;
    logic [DATA_W-1:0] sreg;
    logic [CRC_W-1:0]  crc_q;
    logic [CRC_W-1:0]  crc_step;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              last;
`ifdef SD_CRC_CHECK_EN
    logic [CRC_W-1:0]  crc_cap;
`endif

    sd_crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .crc      (crc_q),
        .din      (sreg[DATA_W-1]),
        .crc_next (crc_step)
    );

    // abort beats start; a start while shifting is dropped.
    assign accept = (state != SHIFT) && start && !abort;
    assign last   = (state == SHIFT) && (cnt == LAST);
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = SHIFT;
            SHIFT: begin
                if (abort)     state_n = IDLE;
                else if (last) state_n = DONE;
            end
            DONE:    state_n = accept ? SHIFT : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            sreg    <= '0;
            crc_q   <= '0;
            cnt     <= '0;
            crc_o   <= '0;
`ifdef SD_CRC_CHECK_EN
            crc_cap <= '0;
            crc_err <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (accept) begin
                sreg    <= data_i;
                crc_q   <= INIT;
                cnt     <= '0;
`ifdef SD_CRC_CHECK_EN
                crc_cap <= crc_i;
`endif
            end else if ((state == SHIFT) && !abort) begin
                sreg  <= sreg << 1;
                crc_q <= crc_step;
                cnt   <= cnt + 1'b1;
                if (last) begin
                    crc_o   <= crc_step;
`ifdef SD_CRC_CHECK_EN
                    crc_err <= (crc_step != crc_cap);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_crc_serial.sv
// tb/tb_sd_crc_serial.sv - self-checking bench for sd_crc_serial (CRC7 CMD and CRC16 DAT builds)
module tb_sd_crc_serial;
    import sd_crc_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic          start7 = 1'b0, abort7 = 1'b0;
    logic [39:0]   data7 = '0;
    logic          busy7, done7;
    logic [6:0]    crc7;

    logic          start16 = 1'b0, abort16 = 1'b0;
    logic [4095:0] data16 = '0;
    logic          busy16, done16;
    logic [15:0]   crc16;

`ifdef SD_CRC_CHECK_EN
    logic [6:0]    crci7 = '0;
    logic          err7;
    logic [15:0]   crci16 = '0;
    logic          err16;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sd_crc_serial u_crc7 (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start7),
        .abort  (abort7),
        .data_i (data7),
`ifdef SD_CRC_CHECK_EN
        .crc_i  (crci7),
        .crc_err(err7),
`endif
        .busy   (busy7),
        .done   (done7),
        .crc_o  (crc7)
    );

    sd_crc_serial #(
        .CRC_W  (16),
        .POLY   (SD_CRC16_POLY),
        .DATA_W (SD_BLK_BITS),
        .INIT   (16'h0000)
    ) u_crc16 (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start16),
        .abort  (abort16),
        .data_i (data16),
`ifdef SD_CRC_CHECK_EN
        .crc_i  (crci16),
        .crc_err(err16),
`endif
        .busy   (busy16),
        .done   (done16),
        .crc_o  (crc16)
    );

    // Reference: remainder of M(x)*x^W divided by the full generator polynomial.
    function automatic logic [6:0] model7(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [15:0] model16(input logic [4095:0] d);
        logic [4111:0] r;
        r = {d, 16'b0};
        for (int i = 4111; i >= 16; i--)
            if (r[i]) r[i -: 17] = r[i -: 17] ^ 17'h11021;
        return r[15:0];
    endfunction

    task automatic wait_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Cycle 0 holds start; returns the cycle index of done, busy cycles seen and crc_o at done.
    task automatic run7(input logic [39:0] d, output int done_cyc, output int busy_cyc,
                        output logic [6:0] res);
        data7    = d;
        start7   = 1'b1;
        wait_cycle();
        start7   = 1'b0;
        done_cyc = -1;
        busy_cyc = 0;
        res      = 'x;
        for (int c = 1; c <= 200; c++) begin
            if (busy7) busy_cyc++;
            if (done7) begin
                done_cyc = c;
                res      = crc7;
                break;
            end
            wait_cycle();
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy7, done7, crc7} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset7 busy=%b done=%b crc=%h exp 0/0/00", busy7, done7, crc7);
        end
        n_checks++;
        if ({busy16, done16, crc16} !== 18'b0) begin
            n_fail++;
            $display("FAIL reset16 busy=%b done=%b crc=%h exp 0/0/0000", busy16, done16, crc16);
        end
`ifdef SD_CRC_CHECK_EN
        n_checks++;
        if ({err7, err16} !== 2'b0) begin
            n_fail++;
            $display("FAIL reset_err err7=%b err16=%b exp 0", err7, err16);
        end
`endif
        RST = 1'b0;
        wait_cycle();
        n_checks++;
        if ({busy7, done7, crc7} !== 9'b0) begin
            n_fail++;
            $display("FAIL post_reset busy=%b done=%b crc=%h exp 0/0/00", busy7, done7, crc7);
        end
    endtask

    task automatic test_cmd0();
        int dc, bc;
        logic [6:0] r;
        run7(40'h4000000000, dc, bc, r);
        n_checks++;
        if (dc !== 41) begin n_fail++; $display("FAIL cmd0_done_cycle got %0d exp 41", dc); end
        n_checks++;
        if (bc !== 40) begin n_fail++; $display("FAIL cmd0_busy_cycles got %0d exp 40", bc); end
        n_checks++;
        if (r !== 7'h4A) begin n_fail++; $display("FAIL cmd0_crc got %h exp 4a", r); end
        wait_cycle();
        n_checks++;
        if (done7 !== 1'b0 || busy7 !== 1'b0 || crc7 !== 7'h4A) begin
            n_fail++;
            $display("FAIL cmd0_after done=%b busy=%b crc=%h exp 0/0/4a", done7, busy7, crc7);
        end
    endtask

    task automatic test_back_to_back();
        int dc, bc, gap;
        logic [6:0] r;
        run7(40'h48000001AA, dc, bc, r);
        n_checks++;
        if (r !== 7'h43 || dc !== 41) begin
            n_fail++;
            $display("FAIL cmd8 crc=%h cycle=%0d exp 43 at 41", r, dc);
        end
        data7  = 40'h5100000000;
        start7 = 1'b1;
        wait_cycle();
        start7 = 1'b0;
        gap    = -1;
        for (int c = 1; c <= 200; c++) begin
            if (done7) begin
                gap = c;
                r   = crc7;
                break;
            end
            wait_cycle();
        end
        n_checks++;
        if (gap !== 41) begin n_fail++; $display("FAIL b2b_gap got %0d exp 41", gap); end
        n_checks++;
        if (r !== 7'h2A) begin n_fail++; $display("FAIL cmd17_crc got %h exp 2a", r); end
        wait_cycle();
    endtask

    task automatic test_random();
        int dc, bc;
        logic [6:0]  r;
        logic [39:0] d;
        for (int k = 0; k < 20; k++) begin
            if (k == 0)      d = '0;
            else if (k == 1) d = '1;
            else             d = {$urandom_range(255, 0), $urandom()};
            run7(d, dc, bc, r);
            n_checks++;
            if (r !== model7(d) || dc !== 41) begin
                n_fail++;
                $display("FAIL random7 data=%h crc=%h cycle=%0d exp %h at 41", d, r, dc, model7(d));
            end
            wait_cycle();
        end
    endtask

    task automatic test_abort();
        int dc, bc;
        logic [6:0] r;
        logic       saw_done;
        run7(40'h48000001AA, dc, bc, r);
        wait_cycle();
        data7    = 40'h4000000000;
        start7   = 1'b1;
        wait_cycle();
        start7   = 1'b0;
        saw_done = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 10) abort7 = 1'b1;
            if (c == 11) abort7 = 1'b0;
            if (c == 12) begin
                n_checks++;
                if (busy7 !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy7); end
            end
            if (done7) saw_done = 1'b1;
            wait_cycle();
        end
        n_checks++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got done=%b exp 0", saw_done); end
        n_checks++;
        if (crc7 !== 7'h43) begin n_fail++; $display("FAIL abort_hold crc=%h exp 43", crc7); end
    endtask

    task automatic test_start_ignored();
        int dc;
        logic [6:0] r;
        logic       extra;
        data7  = 40'h4000000000;
        start7 = 1'b1;
        wait_cycle();
        start7 = 1'b0;
        dc     = -1;
        r      = 'x;
        for (int c = 1; c <= 200; c++) begin
            if (c == 15) begin data7 = 40'h5100000000; start7 = 1'b1; end
            if (c == 16) start7 = 1'b0;
            if (done7) begin dc = c; r = crc7; break; end
            wait_cycle();
        end
        n_checks++;
        if (dc !== 41 || r !== 7'h4A) begin
            n_fail++;
            $display("FAIL start_in_shift crc=%h cycle=%0d exp 4a at 41", r, dc);
        end
        extra = 1'b0;
        for (int c = 0; c < 5; c++) begin
            wait_cycle();
            if (busy7 || done7) extra = 1'b1;
        end
        n_checks++;
        if (extra !== 1'b0) begin n_fail++; $display("FAIL start_not_queued got activity=%b exp 0", extra); end
    endtask

    task automatic test_rst_mid();
        int dc, bc;
        logic [6:0] r;
        data7  = 40'h48000001AA;
        start7 = 1'b1;
        wait_cycle();
        start7 = 1'b0;
        repeat (19) wait_cycle();
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if ({busy7, done7, crc7} !== 9'b0) begin
            n_fail++;
            $display("FAIL rst_mid busy=%b done=%b crc=%h exp 0/0/00", busy7, done7, crc7);
        end
        wait_cycle();
        RST = 1'b0;
        wait_cycle();
        run7(40'h4000000000, dc, bc, r);
        n_checks++;
        if (r !== 7'h4A || dc !== 41) begin
            n_fail++;
            $display("FAIL rst_then_cmd0 crc=%h cycle=%0d exp 4a at 41", r, dc);
        end
        wait_cycle();
    endtask

    task automatic test_crc16();
        int dc;
        logic [15:0] r, exp16;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) data16 = '1;
            else for (int i = 0; i < 128; i++) data16[i*32 +: 32] = $urandom();
            exp16   = (k == 0) ? 16'h7FA1 : model16(data16);
            start16 = 1'b1;
            wait_cycle();
            start16 = 1'b0;
            dc      = -1;
            r       = 'x;
            for (int c = 1; c <= 5000; c++) begin
                if (done16) begin dc = c; r = crc16; break; end
                wait_cycle();
            end
            n_checks++;
            if (dc !== 4097) begin n_fail++; $display("FAIL crc16_done_cycle[%0d] got %0d exp 4097", k, dc); end
            n_checks++;
            if (r !== exp16 || r !== model16(data16)) begin
                n_fail++;
                $display("FAIL crc16_value[%0d] got %h exp %h", k, r, exp16);
            end
            wait_cycle();
        end
    endtask

`ifdef SD_CRC_CHECK_EN
    task automatic test_check();
        int dc, bc;
        logic [6:0] r;
        crci7 = 7'h4A;
        run7(40'h4000000000, dc, bc, r);
        n_checks++;
        if (err7 !== 1'b0) begin n_fail++; $display("FAIL check_match err=%b exp 0", err7); end
        wait_cycle();
        crci7 = 7'h4B;
        run7(40'h4000000000, dc, bc, r);
        n_checks++;
        if (err7 !== 1'b1) begin n_fail++; $display("FAIL check_mismatch err=%b exp 1", err7); end
        wait_cycle();
        n_checks++;
        if (err7 !== 1'b1) begin n_fail++; $display("FAIL check_hold err=%b exp 1", err7); end
    endtask
`endif

    initial begin
        repeat (3) wait_cycle();
        test_reset();
        test_cmd0();
        test_back_to_back();
        test_random();
        test_abort();
        test_start_ignored();
        test_rst_mid();
`ifdef SD_CRC_CHECK_EN
        test_check();
`endif
        test_crc16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
